// File: rtl/coleta_pkg.sv
// Shared types and constants for the recycling-station collection controller.
package coleta_pkg;

    // Default parameter values
    localparam int DEB_LEN_DEF     = 3;
    localparam int OPEN_CYCLES_DEF = 4;
    localparam int CNT_W_DEF       = 3;

    // Bin categories as seen on the categoria output
    localparam logic CAT_REC  = 1'b0;
    localparam logic CAT_NREC = 1'b1;

    // Deposit sequencer states
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ABRE   = 2'd1,
        FECHA  = 2'd2
    } estado_t;

endpackage

// File: rtl/filtro_botao.sv
// Button debounce: a press is qualified once DEB_LEN consecutive samples are
// high, and a single-cycle pulse marks the rising edge of that qualification.
module filtro_botao
    import coleta_pkg::*;
#(
    parameter int DEB_LEN = DEB_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic bruto_i,
    output logic pulso_o
);

    logic [DEB_LEN-1:0] amostras_q;
    logic               estavel;
    logic               estavel_ant_q;

    // Sample window and previous qualification state; any low sample restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            amostras_q    <= '0;
            estavel_ant_q <= 1'b0;
        end else begin
            amostras_q    <= {amostras_q[DEB_LEN-2:0], bruto_i};
            estavel_ant_q <= estavel;
        end
    end

    assign estavel = &amostras_q;
    assign pulso_o = estavel & ~estavel_ant_q;

endmodule

// File: rtl/controlador_coleta.sv
// Collection-point controller: debounces both category buttons, arbitrates
// deposits, runs the hatch open/close sequence and keeps saturating bin counts.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   OCIOSO | idle, hatch closed, waiting for a press to a non-full bin
//   ABRE   | hatch open for OPEN_CYCLES cycles
//   FECHA  | hatch closed for one cycle; served bin counted on exit
module controlador_coleta
    import coleta_pkg::*;
#(
    parameter int DEB_LEN     = DEB_LEN_DEF,
    parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             botao_rec,
    input  logic             botao_nrec,
    input  logic             esvaziar,
    output logic             porta_aberta,
    output logic             categoria,
    output logic             ocupado,
    output logic             rejeitado,
    output logic [CNT_W-1:0] cont_rec,
    output logic [CNT_W-1:0] cont_nrec,
    output logic             cheio_rec,
    output logic             cheio_nrec
);

    // Open timer counts down from OPEN_CYCLES-1; ABRE ends at terminal count zero
    localparam int               TMR_W    = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);

    logic             pulso_rec;
    logic             pulso_nrec;

    estado_t          estado_q, estado_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ultimo_q, ultimo_d;
    logic             cat_q, cat_d;
    logic             rej_q, rej_d;
    logic [CNT_W-1:0] cont_rec_q, cont_rec_d;
    logic [CNT_W-1:0] cont_nrec_q, cont_nrec_d;

    logic             eleg_rec;
    logic             eleg_nrec;
    logic             concede;
    logic             cat_conc;

    filtro_botao #(.DEB_LEN(DEB_LEN)) u_filtro_rec (
        .clk     (clk),
        .reset   (reset),
        .bruto_i (botao_rec),
        .pulso_o (pulso_rec)
    );

    filtro_botao #(.DEB_LEN(DEB_LEN)) u_filtro_nrec (
        .clk     (clk),
        .reset   (reset),
        .bruto_i (botao_nrec),
        .pulso_o (pulso_nrec)
    );

    assign cheio_rec  = &cont_rec_q;
    assign cheio_nrec = &cont_nrec_q;
    assign cont_rec   = cont_rec_q;
    assign cont_nrec  = cont_nrec_q;
    assign categoria  = cat_q;
    assign rejeitado  = rej_q;

    // Arbitration: grant only in idle, round-robin on ties; every ungranted press is dropped
    always_comb begin
        eleg_rec  = pulso_rec & ~cheio_rec;
        eleg_nrec = pulso_nrec & ~cheio_nrec;
        concede   = (estado_q == OCIOSO) & (eleg_rec | eleg_nrec);
        if (eleg_rec & eleg_nrec) begin
            cat_conc = ~ultimo_q;
        end else begin
            cat_conc = eleg_nrec ? CAT_NREC : CAT_REC;
        end
        rej_d = (pulso_rec  & ~(concede & (cat_conc == CAT_REC)))
              | (pulso_nrec & ~(concede & (cat_conc == CAT_NREC)));
    end

    // State register; reset closes the hatch immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:  if (concede) estado_d = ABRE;
            ABRE:    if (tmr_q == '0) estado_d = FECHA;
            FECHA:   estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Hatch and busy outputs decoded from the current state
    always_comb begin
        porta_aberta = 1'b0;
        ocupado      = 1'b0;
        case (estado_q)
            ABRE: begin
                porta_aberta = 1'b1;
                ocupado      = 1'b1;
            end
            FECHA: begin
                ocupado = 1'b1;
            end
            default: begin
                porta_aberta = 1'b0;
                ocupado      = 1'b0;
            end
        endcase
    end

    // Next values for open timer, grant bookkeeping and bin counters
    always_comb begin
        tmr_d = tmr_q;
        if (concede) begin
            tmr_d = TMR_LOAD;
        end else if ((estado_q == ABRE) && (tmr_q != '0)) begin
            tmr_d = tmr_q - 1'b1;
        end

        ultimo_d = concede ? cat_conc : ultimo_q;
        cat_d    = concede ? cat_conc : cat_q;

        cont_rec_d  = cont_rec_q;
        cont_nrec_d = cont_nrec_q;
        if (esvaziar) begin
            cont_rec_d  = '0;
            cont_nrec_d = '0;
        end else if (estado_q == FECHA) begin
            if ((cat_q == CAT_REC) && !cheio_rec) begin
                cont_rec_d = cont_rec_q + 1'b1;
            end
            if ((cat_q == CAT_NREC) && !cheio_nrec) begin
                cont_nrec_d = cont_nrec_q + 1'b1;
            end
        end
    end

    // Datapath registers; last grant resets to nrec so rec wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q       <= '0;
            ultimo_q    <= CAT_NREC;
            cat_q       <= CAT_REC;
            rej_q       <= 1'b0;
            cont_rec_q  <= '0;
            cont_nrec_q <= '0;
        end else begin
            tmr_q       <= tmr_d;
            ultimo_q    <= ultimo_d;
            cat_q       <= cat_d;
            rej_q       <= rej_d;
            cont_rec_q  <= cont_rec_d;
            cont_nrec_q <= cont_nrec_d;
        end
    end

endmodule

// File: tb/tb_controlador_coleta.sv
// Directed bench for controlador_coleta with default parameters
// (DEB_LEN=3, OPEN_CYCLES=4, CNT_W=3).
module tb_controlador_coleta;

    logic       clk;
    logic       reset;
    logic       botao_rec;
    logic       botao_nrec;
    logic       esvaziar;
    logic       porta_aberta;
    logic       categoria;
    logic       ocupado;
    logic       rejeitado;
    logic [2:0] cont_rec;
    logic [2:0] cont_nrec;
    logic       cheio_rec;
    logic       cheio_nrec;

    int n_total = 0;
    int n_bad   = 0;
    int rej_cnt = 0;

    controlador_coleta dut (
        .clk          (clk),
        .reset        (reset),
        .botao_rec    (botao_rec),
        .botao_nrec   (botao_nrec),
        .esvaziar     (esvaziar),
        .porta_aberta (porta_aberta),
        .categoria    (categoria),
        .ocupado      (ocupado),
        .rejeitado    (rejeitado),
        .cont_rec     (cont_rec),
        .cont_nrec    (cont_nrec),
        .cheio_rec    (cheio_rec),
        .cheio_nrec   (cheio_nrec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rejection pulses seen while out of reset
    always @(negedge clk) begin
        if (reset && rejeitado) rej_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full rec deposit from idle: press held 3 samples, hatch cycle, back to idle
    task automatic deposito_rec();
        botao_rec = 1'b1;
        tick(3);
        botao_rec = 1'b0;
        tick(6);
    endtask

    logic [5:0] padrao;

    initial begin
        reset      = 1'b0;
        botao_rec  = 1'b0;
        botao_nrec = 1'b0;
        esvaziar   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Reset state
        chk("rst_porta",   porta_aberta, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_rej",     rejeitado, 0);
        chk("rst_cat",     categoria, 0);
        chk("rst_crec",    cont_rec, 0);
        chk("rst_cnrec",   cont_nrec, 0);
        chk("rst_cheio",   {cheio_rec, cheio_nrec}, 0);

        // Single press: rec held 6 cycles
        botao_rec = 1'b1;
        tick(3);
        chk("t1_porta_e3", porta_aberta, 0);
        tick(1);
        chk("t1_porta_e4", porta_aberta, 1);
        chk("t1_ocup_e4",  ocupado, 1);
        chk("t1_cat",      categoria, 0);
        tick(2);
        botao_rec = 1'b0;
        tick(1);
        chk("t1_porta_e7", porta_aberta, 1);
        tick(1);
        chk("t1_porta_e8", porta_aberta, 0);
        chk("t1_ocup_e8",  ocupado, 1);
        chk("t1_crec_e8",  cont_rec, 0);
        tick(1);
        chk("t1_ocup_e9",  ocupado, 0);
        chk("t1_crec_e9",  cont_rec, 1);
        chk("t1_no_rej",   rej_cnt, 0);

        // Bounce: nrec samples 1,1,0,1,1,1
        padrao = 6'b111011;
        for (int i = 0; i < 6; i++) begin
            botao_nrec = padrao[i];
            tick(1);
            if (i == 2) chk("t2_ocup_e3", ocupado, 0);
        end
        chk("t2_ocup_e6", ocupado, 0);
        botao_nrec = 1'b0;
        tick(1);
        chk("t2_porta_e7", porta_aberta, 1);
        chk("t2_cat",      categoria, 1);
        tick(4);
        chk("t2_porta_e11", porta_aberta, 0);
        tick(1);
        chk("t2_ocup_e12", ocupado, 0);
        chk("t2_cnrec",    cont_nrec, 1);
        chk("t2_crec",     cont_rec, 1);

        // Empty command, then two ties
        esvaziar = 1'b1;
        tick(1);
        esvaziar = 1'b0;
        chk("t3_clr_rec",  cont_rec, 0);
        chk("t3_clr_nrec", cont_nrec, 0);
        botao_rec  = 1'b1;
        botao_nrec = 1'b1;
        tick(3);
        botao_rec  = 1'b0;
        botao_nrec = 1'b0;
        tick(1);
        chk("t3a_porta", porta_aberta, 1);
        chk("t3a_cat",   categoria, 0);
        chk("t3a_rej",   rejeitado, 1);
        tick(1);
        chk("t3a_rej_off", rejeitado, 0);
        tick(4);
        chk("t3a_ocup", ocupado, 0);
        chk("t3a_crec", cont_rec, 1);
        chk("t3a_cnrec", cont_nrec, 0);
        botao_rec  = 1'b1;
        botao_nrec = 1'b1;
        tick(3);
        botao_rec  = 1'b0;
        botao_nrec = 1'b0;
        tick(1);
        chk("t3b_cat", categoria, 1);
        chk("t3b_rej", rejeitado, 1);
        tick(5);
        chk("t3b_crec",  cont_rec, 1);
        chk("t3b_cnrec", cont_nrec, 1);

        // Busy drop: nrec qualifies during rec's open window
        botao_rec = 1'b1;
        tick(3);
        botao_rec = 1'b0;
        tick(1);
        botao_nrec = 1'b1;
        tick(3);
        chk("t4_rej_e7",  rejeitado, 0);
        tick(1);
        chk("t4_rej_e8",  rejeitado, 1);
        chk("t4_porta_e8", porta_aberta, 0);
        chk("t4_ocup_e8", ocupado, 1);
        tick(1);
        chk("t4_ocup_e9", ocupado, 0);
        chk("t4_crec",    cont_rec, 2);
        chk("t4_cnrec",   cont_nrec, 1);
        chk("t4_rej_e9",  rejeitado, 0);
        tick(1);
        chk("t4_held",    ocupado, 0);
        botao_nrec = 1'b0;
        tick(1);

        // Saturation
        esvaziar = 1'b1;
        tick(1);
        esvaziar = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            deposito_rec();
            chk("t5_crec_step", cont_rec, k);
        end
        chk("t5_cheio", cheio_rec, 1);
        botao_rec = 1'b1;
        tick(3);
        botao_rec = 1'b0;
        tick(1);
        chk("t5_full_rej",   rejeitado, 1);
        chk("t5_full_porta", porta_aberta, 0);
        chk("t5_full_ocup",  ocupado, 0);
        chk("t5_crec_sat",   cont_rec, 7);
        esvaziar = 1'b1;
        tick(1);
        esvaziar = 1'b0;
        chk("t5_clr",       cont_rec, 0);
        chk("t5_clr_cheio", cheio_rec, 0);

        // Empty during FECHA wins over the increment
        botao_rec = 1'b1;
        tick(3);
        botao_rec = 1'b0;
        tick(5);
        chk("t5b_fecha", ocupado, 1);
        esvaziar = 1'b1;
        tick(1);
        esvaziar = 1'b0;
        chk("t5b_ocup", ocupado, 0);
        chk("t5b_crec", cont_rec, 0);

        // Reset mid-ABRE
        botao_nrec = 1'b1;
        tick(3);
        botao_nrec = 1'b0;
        tick(6);
        chk("t6_cnrec_pre", cont_nrec, 1);
        botao_rec = 1'b1;
        tick(3);
        botao_rec = 1'b0;
        tick(2);
        chk("t6_porta_pre", porta_aberta, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_porta_rst", porta_aberta, 0);
        chk("t6_ocup_rst",  ocupado, 0);
        chk("t6_cnt_rst",   {cont_rec, cont_nrec}, 0);
        @(negedge clk);
        reset      = 1'b1;
        botao_rec  = 1'b1;
        botao_nrec = 1'b1;
        tick(3);
        botao_rec  = 1'b0;
        botao_nrec = 1'b0;
        tick(1);
        chk("t6_porta_post", porta_aberta, 1);
        chk("t6_cat_post",   categoria, 0);
        chk("t6_rej_post",   rejeitado, 1);
        tick(5);
        chk("t6_crec_post",  cont_rec, 1);
        chk("t6_cnrec_post", cont_nrec, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
